tc_rr_encoder4: RTL and testbench
=================================

Name: tc_rr_encoder4

Overview:
- Registered 4-to-2 round-robin encoder; the encoding counterpart of the 2-to-4 select decoder.
- Accepts four independent request lines and grants one at a time.
- Presents the granted index as a 2-bit code on sel1/sel0 with a valid flag, held until the consumer acknowledges.
- Sits in front of a 2-to-4 decoder so that shared-resource grants round-trip: requests, encoded index, decoded one-hot enables.

Parameters:
- FIXED_PRIORITY, 0, 1 = static priority (in0 highest, in3 lowest) with the rotation pointer ignored; 0 = round-robin.
- TIMEOUT, 15, cycles a grant may stay un-acked before forced release; used only with the optional feature; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low; sampled on the clk rising edge
- in0  input  1  request from source 0
- in1  input  1  request from source 1
- in2  input  1  request from source 2
- in3  input  1  request from source 3
- ack  input  1  consumer accepts the current grant
- sel0  output  1  granted index bit 0, registered
- sel1  output  1  granted index bit 1, registered
- valid  output  1  {sel1,sel0} holds a live grant, registered
- multi  output  1  more than one request was pending when the current grant was taken, registered
- timeout  output  1  one-cycle pulse on forced release; exists only with TC_RR_ENC_TIMEOUT_EN

Behaviour:
- Reset (rst==0 at an edge):
  - sel0=0, sel1=0, valid=0, multi=0, timeout=0.
  - Pointer=0, state=IDLE, timeout counter=0.
  - Reset overrides all other inputs, including mid-grant; the grant is dropped with no ack needed.
- States: IDLE, GRANT (state register, 1 bit).
- IDLE:
  - If any of in0..in3 is 1 at edge N, choose the winner. Round-robin: the first asserted index scanning ptr, ptr+1, ... mod 4. Fixed priority: the lowest asserted index.
  - At edge N: register {sel1,sel0}=winner, set valid=1, set multi=(request count>1), go to GRANT.
  - Latency: request sampled at edge N gives valid high in the cycle after edge N.
  - No requests: remain in IDLE, outputs unchanged except valid=0.
  - ack in IDLE is ignored.
- GRANT:
  - sel, valid and multi are held stable regardless of request lines; a withdrawn request does not revoke the grant.
  - On ack==1 at an edge: valid=0, ptr=(winner+1) mod 4 (2-bit wrap, 3 goes to 0), go to IDLE.
  - sel bits keep their last value after release; they are meaningful only while valid=1.
- Minimum one IDLE cycle between grants. Back-to-back throughput is therefore one grant per 2 cycles when ack is given the same cycle valid rises.
- Simultaneous ack and new requests at the releasing edge: the requests are not evaluated until the next edge (in IDLE).
- With FIXED_PRIORITY=1, ptr still updates but does not affect selection.

Optional Feature:
- Macro: TC_RR_ENC_TIMEOUT_EN.
- Enabled:
  - The timeout port exists and a 4-bit counter runs in GRANT, cleared on entry to GRANT and on reset.
  - When the counter reaches TIMEOUT with no ack, at that edge: valid=0, timeout=1 for exactly one cycle, ptr=(winner+1) mod 4, go to IDLE.
  - ack on the same edge as expiry takes precedence; timeout stays 0.
- Disabled: no timeout port, no counter, and a grant is held indefinitely until ack.

Test Plan:
- Reset: rst=0 for 2 cycles with in0..in3=1111 -> valid=0, sel=00, multi=0. Release rst, hold requests -> next edge valid=1, sel=00, multi=1.
- Rotation: in=1111 held, ack pulsed each time valid=1 -> grant sequence sel=0,1,2,3,0 (round-robin), valid low for one cycle between each grant.
- Wrap and skip: ptr=3 (after a grant of 2), only in1=1 -> sel=01, multi=0. Then only in0=1 -> sel=00.
- Hold: grant on in2 (sel=10); drop in2 and raise in3 while ack=0 for 5 cycles -> sel stays 10, valid stays 1. Then ack -> valid=0; next grant sel=11.
- Fixed priority (FIXED_PRIORITY=1): in=1010 repeatedly acked -> sel=01 every grant. Reset asserted mid-grant -> valid=0 at that edge.
- Timeout (TC_RR_ENC_TIMEOUT_EN, TIMEOUT=4): grant in0 with no ack -> valid falls and timeout=1 for one cycle at the 4th GRANT edge; next grant in1 if pending. Repeat with ack on the expiry edge -> timeout stays 0.

Source files
------------

// File: rtl/tc_rr_encoder4.sv
// Registered 4-to-2 round-robin request encoder with grant/ack handshake.
// Define TC_RR_ENC_TIMEOUT_EN to add forced release of un-acked grants.
module tc_rr_encoder4 #(
    parameter int FIXED_PRIORITY = 0,
    parameter int TIMEOUT        = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic in0,
    input  logic in1,
    input  logic in2,
    input  logic in3,
    input  logic ack,
    output logic sel0,
    output logic sel1,
    output logic valid,
    output logic multi
`ifdef TC_RR_ENC_TIMEOUT_EN
    ,
    output logic timeout
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    if (TIMEOUT < 1 || TIMEOUT > 15) begin : g_bad_timeout
        $error("tc_rr_encoder4: TIMEOUT must be in 1..15");
    end

    function automatic logic [1:0] first_idx(input logic [3:0] v);
        logic [1:0] idx;
        priority case (1'b1)
            v[0]:    idx = 2'd0;
            v[1]:    idx = 2'd1;
            v[2]:    idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] sel_q, sel_d;
    logic       valid_q, valid_d;
    logic       multi_q, multi_d;
`ifdef TC_RR_ENC_TIMEOUT_EN
    logic [3:0] cnt_q, cnt_d;
    logic       to_q, to_d;
`endif

    logic [3:0] req;
    logic [1:0] base;
    logic [7:0] req2;
    logic [3:0] rot;
    logic [1:0] winner;

    assign req  = {in3, in2, in1, in0};
    assign base = (FIXED_PRIORITY != 0) ? 2'd0 : ptr_q;
    assign req2 = {req, req} >> base;
    assign rot  = req2[3:0];
    // Search the rotated vector, then undo the rotation.
    assign winner = base + first_idx(rot);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        multi_d = multi_q;
`ifdef TC_RR_ENC_TIMEOUT_EN
        cnt_d   = cnt_q;
        to_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (|req) begin
                    sel_d   = winner;
                    valid_d = 1'b1;
                    multi_d = (req & (req - 4'd1)) != 4'd0;
                    state_d = GRANT;
`ifdef TC_RR_ENC_TIMEOUT_EN
                    cnt_d   = 4'd0;
`endif
                end
            end
            GRANT: begin
                if (ack) begin
                    valid_d = 1'b0;
                    ptr_d   = sel_q + 2'd1;
                    state_d = IDLE;
`ifdef TC_RR_ENC_TIMEOUT_EN
                end else if (cnt_q == 4'(TIMEOUT - 1)) begin
                    valid_d = 1'b0;
                    ptr_d   = sel_q + 2'd1;
                    state_d = IDLE;
                    to_d    = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            sel_q   <= 2'd0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
`ifdef TC_RR_ENC_TIMEOUT_EN
            cnt_q   <= 4'd0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
`ifdef TC_RR_ENC_TIMEOUT_EN
            cnt_q   <= cnt_d;
            to_q    <= to_d;
`endif
        end
    end

    assign sel0  = sel_q[0];
    assign sel1  = sel_q[1];
    assign valid = valid_q;
    assign multi = multi_q;
`ifdef TC_RR_ENC_TIMEOUT_EN
    assign timeout = to_q;
`endif

endmodule

// File: tb/tb_tc_rr_encoder4.sv
// Random-stimulus bench for tc_rr_encoder4, round-robin and fixed-priority
// instances checked against a cycle-level reference model.
module tb_tc_rr_encoder4;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst, in0, in1, in2, in3, ack;
    logic sel0_r, sel1_r, valid_r, multi_r;
    logic sel0_f, sel1_f, valid_f, multi_f;
`ifdef TC_RR_ENC_TIMEOUT_EN
    logic to_r, to_f;
`endif

    int checks = 0;
    int errors = 0;

    int m_sel[2], m_ptr[2], m_cnt[2];
    bit m_valid[2], m_multi[2], m_to[2];

    always #5 clk = ~clk;

    tc_rr_encoder4 #(.FIXED_PRIORITY(0), .TIMEOUT(TO)) dut_rr (
        .clk(clk), .rst(rst),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3), .ack(ack),
        .sel0(sel0_r), .sel1(sel1_r), .valid(valid_r), .multi(multi_r)
`ifdef TC_RR_ENC_TIMEOUT_EN
        , .timeout(to_r)
`endif
    );

    tc_rr_encoder4 #(.FIXED_PRIORITY(1), .TIMEOUT(TO)) dut_fp (
        .clk(clk), .rst(rst),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3), .ack(ack),
        .sel0(sel0_f), .sel1(sel1_f), .valid(valid_f), .multi(multi_f)
`ifdef TC_RR_ENC_TIMEOUT_EN
        , .timeout(to_f)
`endif
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0d expected %0d",
                     tag, $time, got, exp);
        end
    endtask

    // One clock edge of the specified behaviour for instance m (1 = fixed).
    task automatic model_step(input int m);
        logic [3:0] r;
        int base, w, idx;
        r = {in3, in2, in1, in0};
        m_to[m] = 1'b0;
        if (!rst) begin
            m_sel[m] = 0; m_ptr[m] = 0; m_cnt[m] = 0;
            m_valid[m] = 1'b0; m_multi[m] = 1'b0;
        end else if (!m_valid[m]) begin
            if (r != 4'd0) begin
                base = (m == 1) ? 0 : m_ptr[m];
                w = -1;
                for (int k = 0; k < 4; k++) begin
                    idx = (base + k) % 4;
                    if (w < 0 && r[idx]) w = idx;
                end
                m_sel[m]   = w;
                m_valid[m] = 1'b1;
                m_multi[m] = $countones(r) > 1;
                m_cnt[m]   = 0;
            end
        end else if (ack) begin
            m_valid[m] = 1'b0;
            m_ptr[m]   = (m_sel[m] + 1) % 4;
        end
`ifdef TC_RR_ENC_TIMEOUT_EN
        else begin
            m_cnt[m]++;
            if (m_cnt[m] == TO) begin
                m_valid[m] = 1'b0;
                m_to[m]    = 1'b1;
                m_ptr[m]   = (m_sel[m] + 1) % 4;
            end
        end
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check("rr.sel",   int'({sel1_r, sel0_r}), m_sel[0]);
        check("rr.valid", int'(valid_r), int'(m_valid[0]));
        check("rr.multi", int'(multi_r), int'(m_multi[0]));
        check("fp.sel",   int'({sel1_f, sel0_f}), m_sel[1]);
        check("fp.valid", int'(valid_f), int'(m_valid[1]));
        check("fp.multi", int'(multi_f), int'(m_multi[1]));
`ifdef TC_RR_ENC_TIMEOUT_EN
        check("rr.timeout", int'(to_r), int'(m_to[0]));
        check("fp.timeout", int'(to_f), int'(m_to[1]));
`endif
    endtask

    task automatic set_req(input logic [3:0] r);
        {in3, in2, in1, in0} = r;
    endtask

    initial begin
        rst = 1'b0; ack = 1'b0;
        set_req(4'hF);
        repeat (2) cycle();
        rst = 1'b1;
        // All requesting, ack whenever a grant is live: rotation 0,1,2,3,0.
        for (int i = 0; i < 12; i++) begin
            ack = valid_r;
            cycle();
        end
        ack = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 2) == 0)
                set_req(4'(1 << $urandom_range(0, 3)));
            else
                set_req(4'($urandom));
            ack = ($urandom_range(0, 1) == 1);
            cycle();
        end
        // Sparse acks so grants linger and any timeout logic expires.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) != 0);
            set_req(4'($urandom));
            ack = ($urandom_range(0, 7) == 0);
            cycle();
        end
        rst = 1'b0;
        cycle();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
